reg_f_ctx: RTL and testbench
============================

# reg_f_ctx

Parametrised register file with a hardware context stack for the soft core. Holds constants R0 = 0 and R1 = all-ones, the accumulator at R2, and work registers R3..R(SIZE-1). On a call, a push saves all banked registers R2..R(SIZE-1) one per cycle into an on-chip single-port RAM, then clears them. On a return, a pop restores them.

## Interface
Parameters:
- WIDTH, 8: register width in bits.
- SIZE, 11: total register count including R0 and R1. Must be at least 3. Banked count is NB = SIZE-2.
- DEPTH, 16: maximum number of saved context frames.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous and active-low.
- rf_addr_r1  in  $clog2(SIZE)  read address, port 1.
- rf_data_out1  out  WIDTH  combinational read data, port 1.
- rf_addr_r2  in  $clog2(SIZE)  read address, port 2.
- rf_data_out2  out  WIDTH  combinational read data, port 2.
- rf_addr_wr  in  $clog2(SIZE)  write address.
- rf_data_we  in  1  write enable.
- rf_data_in  in  WIDTH  write data.
- rf_stack_push  in  1  request a context save.
- rf_stack_pop  in  1  request a context restore.
- rf_busy  out  1  high while a save or restore is in progress.
- rf_stack_full  out  1  high when sp == DEPTH.
- rf_stack_empty  out  1  high when sp == 0.
- rf_stack_err  out  1  one-cycle pulse when a request is rejected.
- rf_sp  out  $clog2(DEPTH+1)  number of saved frames.
- rf_acc_zero  out  1  combinational; high when R2 == 0.

## Operation
- Reset (rst_n = 0 at an edge):
  - R0 = 0, R1 = all-ones, R2..R(SIZE-1) = 0.
  - sp = 0, state = IDLE.
  - rf_busy = 0, rf_stack_err = 0, rf_stack_empty = 1, rf_stack_full = 0.
  - RAM contents are not reset.
  - A reset during SAVE or RESTORE aborts the operation; the next cycle is IDLE.
- Writes:
  - Performed only in IDLE, with rf_data_we = 1 and 2 ≤ rf_addr_wr < SIZE.
  - Writes to R0/R1, to addresses ≥ SIZE, or during rf_busy are silently dropped.
- Reads:
  - Always combinational, including while busy.
  - Addresses ≥ SIZE read 0.
- FSM has three states: IDLE, SAVE, RESTORE. Counter k runs 0..NB.
- Push accepted (IDLE, push = 1, pop = 0, not full):
  - Go to SAVE with k = 0.
  - Each SAVE cycle writes R(2+k) to RAM[sp*NB+k].
  - At k = NB-1: sp increments, R2..R(SIZE-1) are cleared to 0, and the FSM returns to IDLE.
- Pop accepted (IDLE, pop = 1, push = 0, not empty):
  - sp decrements at the acceptance edge. Go to RESTORE with k = 0.
  - In cycles k < NB, RAM address sp*NB+k is issued.
  - In cycles k ≥ 1, the RAM output is written to R(2+k-1).
  - At k = NB: return to IDLE.
- Rejected requests pulse rf_stack_err and change no state:
  - push while full;
  - pop while empty;
  - push and pop in the same cycle.
- Requests while busy are ignored with no err pulse. Requesters hold the request until rf_busy = 0.
- A write in the acceptance cycle of a push is performed, and the written value is the one saved.

## Timing
- Request accepted at the edge ending cycle T.
- Push: rf_busy is high in cycles T+1..T+NB (NB cycles). Cleared registers and the new sp are visible from T+NB+1.
- Pop: rf_busy is high in cycles T+1..T+NB+1 (NB+1 cycles, one for RAM read latency). The new sp is visible from T+1. Restored values are visible from T+NB+2.
- rf_busy = (state != IDLE), decoded combinationally from the state register.
- rf_stack_err: registered pulse, high in cycle T+1 for a rejection at edge T.
- rf_acc_zero follows R2 combinationally; it goes high in the cycle after a push completes.
- sp is in the range 0..DEPTH and never wraps.

## Structure
- Package reg_f_pkg holds:
  - the state enum typedef (IDLE, SAVE, RESTORE);
  - constants ZERO_IDX = 0, ONES_IDX = 1, ACC_IDX = 2.
- Sub-module reg_f_ctx_ram: single-port synchronous RAM, WIDTH × (DEPTH*NB), one-cycle registered read, write-enable port.
- The top module contains the register array, FSM, counter k, sp and flags.

## Test plan
All scenarios use WIDTH = 8, SIZE = 11 (NB = 9), DEPTH = 2.
- After reset: read R0 → 0x00, R1 → 0xFF, R2 → 0x00. rf_acc_zero = 1, empty = 1, rf_sp = 0.
- Write 0x5A to R1, then 0x3C to R2: R1 still reads 0xFF, R2 reads 0x3C, rf_acc_zero = 0.
- Load R2..R10 = 0x10..0x18, push:
  - rf_busy is high for 9 cycles, then R2..R10 = 0 and rf_sp = 1;
  - load new values, push, pop: values restored after 10 busy cycles;
  - pop again: 0x10..0x18 restored, empty = 1.
- Push twice (full = 1), then push a third time: rf_stack_err pulses once, rf_sp stays 2, registers are unchanged. Pop with sp = 0: err pulses once.
- Push and pop together in IDLE: err pulses, and state, sp and registers are unchanged. A write to R5 during rf_busy is dropped.
- Assert rst_n = 0 in the 4th SAVE cycle: next cycle IDLE, rf_busy = 0, rf_sp = 0, all banked registers 0.

Source files
------------

// File: rtl/reg_f_pkg.sv
// Shared types and fixed register indices for the context-stacked register file.
package reg_f_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    localparam int ZERO_IDX = 0;
    localparam int ONES_IDX = 1;
    localparam int ACC_IDX  = 2;

endpackage

// File: rtl/reg_f_ctx_ram.sv
// Single-port context RAM: synchronous write, one-cycle registered read.
module reg_f_ctx_ram #(
    parameter int WIDTH = 8,
    parameter int WORDS = 144,
    parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/reg_f_ctx.sv
// Register file with constant R0/R1, accumulator R2 and a hardware stack that
// saves/restores the banked registers R2..R(SIZE-1) one word per cycle.
module reg_f_ctx
    import reg_f_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIZE  = 11,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(SIZE)-1:0]    rf_addr_r1,
    output logic [WIDTH-1:0]           rf_data_out1,
    input  logic [$clog2(SIZE)-1:0]    rf_addr_r2,
    output logic [WIDTH-1:0]           rf_data_out2,
    input  logic [$clog2(SIZE)-1:0]    rf_addr_wr,
    input  logic                       rf_data_we,
    input  logic [WIDTH-1:0]           rf_data_in,
    input  logic                       rf_stack_push,
    input  logic                       rf_stack_pop,
    output logic                       rf_busy,
    output logic                       rf_stack_full,
    output logic                       rf_stack_empty,
    output logic                       rf_stack_err,
    output logic [$clog2(DEPTH+1)-1:0] rf_sp,
    output logic                       rf_acc_zero
);

    localparam int NB     = SIZE - 2;
    localparam int AW_R   = $clog2(SIZE);
    localparam int K_W    = $clog2(NB + 1);
    localparam int SP_W   = $clog2(DEPTH + 1);
    localparam int WORDS  = DEPTH * NB;
    localparam int RAM_AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t                      state_reg, state_next;
    logic [K_W-1:0]              k_reg, k_next;
    logic [SP_W-1:0]             sp_reg, sp_next;
    logic                        err_reg, err_next;
    logic [NB-1:0][WIDTH-1:0]    bank;
    logic                        full, empty;
    logic                        idle_wr, save_last, restore_wr, ram_we;
    logic [RAM_AW-1:0]           ram_addr;
    logic [WIDTH-1:0]            ram_wdata, ram_rdata;

    function automatic logic [WIDTH-1:0] read_port(
        input logic [AW_R-1:0]          a,
        input logic [NB-1:0][WIDTH-1:0] b
    );
        logic [WIDTH-1:0] d;
        d = '0;
        if (int'(a) == ONES_IDX) d = '1;
        for (int i = 0; i < NB; i++) begin
            if (int'(a) == i + ACC_IDX) d = b[i];
        end
        return d;
    endfunction

    assign full       = (sp_reg == SP_W'(DEPTH));
    assign empty      = (sp_reg == '0);
    assign idle_wr    = (state_reg == IDLE) && rf_data_we &&
                        (int'(rf_addr_wr) >= ACC_IDX) && (int'(rf_addr_wr) < SIZE);
    assign save_last  = (state_reg == SAVE) && (k_reg == K_W'(NB - 1));
    // RAM data lags the issued address by one cycle, so register k-1 is loaded.
    assign restore_wr = (state_reg == RESTORE) && (k_reg != '0);
    assign ram_we     = (state_reg == SAVE);

    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
        logic [WIDTH-1:0] r_reg;
        always_ff @(posedge clk) begin
            if (!rst_n || save_last) begin
                r_reg <= '0;
            end else if (restore_wr && int'(k_reg) == gi + 1) begin
                r_reg <= ram_rdata;
            end else if (idle_wr && int'(rf_addr_wr) == gi + ACC_IDX) begin
                r_reg <= rf_data_in;
            end
        end
        assign bank[gi] = r_reg;
    end

    always_comb begin
        ram_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            if (int'(k_reg) == i) ram_wdata = bank[i];
        end
        ram_addr = '0;
        if (k_reg < K_W'(NB)) begin
            ram_addr = RAM_AW'(int'(sp_reg) * NB + int'(k_reg));
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        sp_next    = sp_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rf_stack_push && rf_stack_pop) begin
                    err_next = 1'b1;
                end else if (rf_stack_push) begin
                    if (full) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = SAVE;
                        k_next     = '0;
                    end
                end else if (rf_stack_pop) begin
                    if (empty) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = RESTORE;
                        k_next     = '0;
                        sp_next    = sp_reg - 1'b1;
                    end
                end
            end
            SAVE: begin
                if (k_reg == K_W'(NB - 1)) begin
                    state_next = IDLE;
                    k_next     = '0;
                    sp_next    = sp_reg + 1'b1;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            RESTORE: begin
                if (k_reg == K_W'(NB)) begin
                    state_next = IDLE;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            sp_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            sp_reg    <= sp_next;
            err_reg   <= err_next;
        end
    end

    reg_f_ctx_ram #(
        .WIDTH (WIDTH),
        .WORDS (WORDS),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign rf_data_out1   = read_port(rf_addr_r1, bank);
    assign rf_data_out2   = read_port(rf_addr_r2, bank);
    assign rf_busy        = (state_reg != IDLE);
    assign rf_stack_full  = full;
    assign rf_stack_empty = empty;
    assign rf_stack_err   = err_reg;
    assign rf_sp          = sp_reg;
    assign rf_acc_zero    = (bank[0] == '0);

endmodule

// File: tb/tb_reg_f_ctx.sv
// Bench for reg_f_ctx: register/stack behaviour checked against a queue-based model.
module tb_reg_f_ctx;

    localparam int WIDTH = 8;
    localparam int SIZE  = 11;
    localparam int DEPTH = 2;
    localparam int NB    = SIZE - 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rf_addr_r1 = '0, rf_addr_r2 = '0, rf_addr_wr = '0;
    logic [7:0] rf_data_out1, rf_data_out2, rf_data_in = '0;
    logic       rf_data_we = 1'b0, rf_stack_push = 1'b0, rf_stack_pop = 1'b0;
    logic       rf_busy, rf_stack_full, rf_stack_empty, rf_stack_err, rf_acc_zero;
    logic [1:0] rf_sp;

    always #5 clk = ~clk;

    reg_f_ctx #(.WIDTH(WIDTH), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rf_addr_r1(rf_addr_r1), .rf_data_out1(rf_data_out1),
        .rf_addr_r2(rf_addr_r2), .rf_data_out2(rf_data_out2),
        .rf_addr_wr(rf_addr_wr), .rf_data_we(rf_data_we), .rf_data_in(rf_data_in),
        .rf_stack_push(rf_stack_push), .rf_stack_pop(rf_stack_pop),
        .rf_busy(rf_busy), .rf_stack_full(rf_stack_full), .rf_stack_empty(rf_stack_empty),
        .rf_stack_err(rf_stack_err), .rf_sp(rf_sp), .rf_acc_zero(rf_acc_zero)
    );

    int errors = 0;
    int checks = 0;

    // Model: architectural registers (addresses >= SIZE read 0) and a flat stack of saved words.
    logic [7:0] mregs  [16];
    logic [7:0] mstack [$];
    logic [7:0] obs1   [16];
    logic [7:0] obs2   [16];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mregs[1] = 8'hFF;
        mstack.delete();
    endtask

    function automatic int msp();
        return mstack.size() / NB;
    endfunction

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            rf_addr_r1 = 4'(a);
            rf_addr_r2 = 4'(15 - a);
            #1;
            obs1[a]      = rf_data_out1;
            obs2[15 - a] = rf_data_out2;
        end
    endtask

    task automatic write_reg(input logic [3:0] wa, input logic [7:0] wd);
        rf_data_we = 1'b1; rf_addr_wr = wa; rf_data_in = wd;
        step();
        rf_data_we = 1'b0;
        if (int'(wa) >= 2 && int'(wa) < SIZE) mregs[wa] = wd;
    endtask

    task automatic load_random();
        for (int a = 2; a < SIZE; a++) write_reg(4'(a), 8'($urandom));
    endtask

    task automatic model_req(input logic p, input logic q, input logic we,
                             input logic [3:0] wa, input logic [7:0] wd,
                             output int eb, output int ee, output int esp);
        int sp;
        sp = msp(); eb = 0; ee = 0; esp = sp;
        if (we && int'(wa) >= 2 && int'(wa) < SIZE) mregs[wa] = wd;
        if (p && q) begin
            ee = 1;
        end else if (p) begin
            if (sp == DEPTH) ee = 1;
            else begin
                for (int i = 2; i < SIZE; i++) begin
                    mstack.push_back(mregs[i]);
                    mregs[i] = 8'h00;
                end
                eb = NB;
            end
        end else if (q) begin
            if (sp == 0) ee = 1;
            else begin
                for (int i = SIZE - 1; i >= 2; i--) mregs[i] = mstack.pop_back();
                eb = NB + 1;
                esp = sp - 1;
            end
        end
    endtask

    // Drives one request; reports busy length, err pulses and sp seen in the first cycle after acceptance.
    task automatic do_req(input logic p, input logic q, input logic we,
                          input logic [3:0] wa, input logic [7:0] wd,
                          output int busy_cnt, output int err_cnt, output int sp_first);
        rf_stack_push = p; rf_stack_pop = q; rf_data_we = we; rf_addr_wr = wa; rf_data_in = wd;
        step();
        rf_stack_push = 1'b0; rf_stack_pop = 1'b0; rf_data_we = 1'b0;
        sp_first = int'(rf_sp); busy_cnt = 0; err_cnt = 0;
        while (rf_busy && busy_cnt < 40) begin
            if (rf_stack_err) err_cnt++;
            busy_cnt++;
            step();
        end
        if (rf_stack_err) err_cnt++;
        step();
        if (rf_stack_err) err_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        model_reset();
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (obs1[a] !== mregs[a] || obs2[a] !== mregs[a]) begin
                errors++;
                $display("FAIL reset_reg r%0d: got %h/%h want %h", a, obs1[a], obs2[a], mregs[a]);
            end
        end
        checks++;
        if ({rf_acc_zero, rf_stack_empty, rf_stack_full, rf_busy, rf_stack_err, rf_sp} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_flags: got acc_zero=%b empty=%b full=%b busy=%b err=%b sp=%0d want 1 1 0 0 0 0",
                     rf_acc_zero, rf_stack_empty, rf_stack_full, rf_busy, rf_stack_err, rf_sp);
        end
    endtask

    task automatic test_write_protect();
        write_reg(4'd1, 8'h5A);
        write_reg(4'd0, 8'h77);
        write_reg(4'd12, 8'h99);
        write_reg(4'd2, 8'h3C);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (obs1[a] !== mregs[a] || obs2[a] !== mregs[a]) begin
                errors++;
                $display("FAIL write_reg r%0d: got %h/%h want %h", a, obs1[a], obs2[a], mregs[a]);
            end
        end
        checks++;
        if (rf_acc_zero !== 1'b0) begin
            errors++;
            $display("FAIL write_acc_zero: got %b want 0", rf_acc_zero);
        end
    endtask

    task automatic test_push_pop();
        int b, e, s, eb, ee, es;
        for (int a = 2; a < SIZE; a++) write_reg(4'(a), 8'(8'h10 + a - 2));
        for (int n = 0; n < 4; n++) begin
            // n: push, push with a write in the acceptance cycle, pop, pop
            if (n == 1) load_random();
            if (n < 2) begin
                model_req(1'b1, 1'b0, n == 1, 4'd3, 8'hC7, eb, ee, es);
                do_req(1'b1, 1'b0, n == 1, 4'd3, 8'hC7, b, e, s);
            end else begin
                model_req(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, eb, ee, es);
                do_req(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, b, e, s);
            end
            checks++;
            if (b !== eb || e !== ee || s !== es) begin
                errors++;
                $display("FAIL push_pop_timing op%0d: got busy=%0d err=%0d sp_first=%0d want %0d %0d %0d",
                         n, b, e, s, eb, ee, es);
            end
            read_all();
            for (int a = 0; a < 16; a++) begin
                checks++;
                if (obs1[a] !== mregs[a] || obs2[a] !== mregs[a]) begin
                    errors++;
                    $display("FAIL push_pop_reg op%0d r%0d: got %h/%h want %h", n, a, obs1[a], obs2[a], mregs[a]);
                end
            end
            checks++;
            if (int'(rf_sp) !== msp() || rf_stack_empty !== (msp() == 0) ||
                rf_stack_full !== (msp() == DEPTH) || rf_acc_zero !== (mregs[2] == 8'h00)) begin
                errors++;
                $display("FAIL push_pop_flags op%0d: got sp=%0d empty=%b full=%b acc_zero=%b want sp=%0d",
                         n, rf_sp, rf_stack_empty, rf_stack_full, rf_acc_zero, msp());
            end
        end
    endtask

    task automatic test_overflow();
        int b, e, s, eb, ee, es;
        logic p;
        // ops: push, push, push(rejected), pop, pop, pop(rejected)
        for (int n = 0; n < 6; n++) begin
            p = (n < 3);
            load_random();
            model_req(p, !p, 1'b0, 4'd0, 8'h00, eb, ee, es);
            do_req(p, !p, 1'b0, 4'd0, 8'h00, b, e, s);
            checks++;
            if (b !== eb || e !== ee || s !== es) begin
                errors++;
                $display("FAIL overflow_timing op%0d: got busy=%0d err=%0d sp_first=%0d want %0d %0d %0d",
                         n, b, e, s, eb, ee, es);
            end
            read_all();
            for (int a = 0; a < 16; a++) begin
                checks++;
                if (obs1[a] !== mregs[a]) begin
                    errors++;
                    $display("FAIL overflow_reg op%0d r%0d: got %h want %h", n, a, obs1[a], mregs[a]);
                end
            end
            checks++;
            if (int'(rf_sp) !== msp() || rf_stack_full !== (msp() == DEPTH) || rf_stack_empty !== (msp() == 0)) begin
                errors++;
                $display("FAIL overflow_flags op%0d: got sp=%0d full=%b empty=%b want sp=%0d",
                         n, rf_sp, rf_stack_full, rf_stack_empty, msp());
            end
        end
    endtask

    task automatic test_conflict_and_busy_write();
        int b, e, s, eb, ee, es, guard;
        load_random();
        model_req(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, eb, ee, es);
        do_req(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, b, e, s);
        checks++;
        if (b !== eb || e !== ee || s !== es || int'(rf_sp) !== msp()) begin
            errors++;
            $display("FAIL conflict: got busy=%0d err=%0d sp=%0d want %0d %0d %0d", b, e, rf_sp, eb, ee, msp());
        end
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (obs1[a] !== mregs[a]) begin
                errors++;
                $display("FAIL conflict_reg r%0d: got %h want %h", a, obs1[a], mregs[a]);
            end
        end
        // Push, then write R5 and raise pop during the first SAVE cycle; both must be ignored.
        model_req(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, eb, ee, es);
        rf_stack_push = 1'b1;
        step();
        rf_stack_push = 1'b0;
        rf_data_we = 1'b1; rf_addr_wr = 4'd5; rf_data_in = ~mstack[3]; rf_stack_pop = 1'b1;
        e = 0; guard = 0;
        if (rf_stack_err) e++;
        step();
        rf_data_we = 1'b0; rf_stack_pop = 1'b0;
        while (rf_busy && guard < 40) begin
            if (rf_stack_err) e++;
            guard++;
            step();
        end
        if (rf_stack_err) e++;
        checks++;
        if (e !== 0 || guard !== NB - 1 || int'(rf_sp) !== msp() || rf_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: got err=%0d rest_busy=%0d sp=%0d busy=%b want 0 %0d %0d 0",
                     e, guard, rf_sp, rf_busy, NB - 1, msp());
        end
        model_req(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, eb, ee, es);
        do_req(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, b, e, s);
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (obs1[a] !== mregs[a]) begin
                errors++;
                $display("FAIL busy_write_reg r%0d: got %h want %h", a, obs1[a], mregs[a]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int b, e, s, eb, ee, es;
        load_random();
        model_req(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, eb, ee, es);
        do_req(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, b, e, s);
        load_random();
        rf_stack_push = 1'b1;
        step();
        rf_stack_push = 1'b0;
        step(); step(); step();
        // Now in the 4th SAVE cycle.
        rst_n = 1'b0;
        step();
        model_reset();
        read_all();
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (obs1[a] !== mregs[a]) begin
                errors++;
                $display("FAIL abort_reg r%0d: got %h want %h", a, obs1[a], mregs[a]);
            end
        end
        checks++;
        if (rf_busy !== 1'b0 || rf_sp !== 2'd0 || rf_stack_empty !== 1'b1 || rf_acc_zero !== 1'b1) begin
            errors++;
            $display("FAIL abort_flags: got busy=%b sp=%0d empty=%b acc_zero=%b want 0 0 1 1",
                     rf_busy, rf_sp, rf_stack_empty, rf_acc_zero);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random_ops();
        int b, e, s, eb, ee, es, op;
        logic p, q, we;
        logic [3:0] wa;
        logic [7:0] wd;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            wa = 4'($urandom_range(0, 15));
            wd = 8'($urandom);
            if (op < 2) begin
                write_reg(wa, wd);
            end else begin
                we = 1'($urandom);
                p  = (op == 2) || ($urandom_range(0, 7) == 0);
                q  = (op == 3) || ($urandom_range(0, 7) == 0);
                model_req(p, q, we, wa, wd, eb, ee, es);
                do_req(p, q, we, wa, wd, b, e, s);
                checks++;
                if (b !== eb || e !== ee || s !== es) begin
                    errors++;
                    $display("FAIL random_req n%0d push=%b pop=%b: got busy=%0d err=%0d sp_first=%0d want %0d %0d %0d",
                             n, p, q, b, e, s, eb, ee, es);
                end
            end
            read_all();
            for (int a = 0; a < 16; a++) begin
                checks++;
                if (obs1[a] !== mregs[a] || obs2[a] !== mregs[a]) begin
                    errors++;
                    $display("FAIL random_reg n%0d r%0d: got %h/%h want %h", n, a, obs1[a], obs2[a], mregs[a]);
                end
            end
            checks++;
            if (int'(rf_sp) !== msp() || rf_stack_empty !== (msp() == 0) ||
                rf_stack_full !== (msp() == DEPTH) || rf_acc_zero !== (mregs[2] == 8'h00)) begin
                errors++;
                $display("FAIL random_flags n%0d: got sp=%0d empty=%b full=%b acc_zero=%b want sp=%0d",
                         n, rf_sp, rf_stack_empty, rf_stack_full, rf_acc_zero, msp());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_protect();
        test_push_pop();
        test_overflow();
        test_conflict_and_busy_write();
        test_reset_abort();
        test_random_ops();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
